// File: rtl/cflog_pkg.sv
// Shared definitions for the CF-Log write controller: state encoding, entry size, address helper.
// Optional build macro CFLOG_LOOP_COMPRESS_EN selects 3-word entries with loop-count compression.
package cflog_pkg;

`ifdef CFLOG_LOOP_COMPRESS_EN
  typedef enum logic [2:0] {IDLE, WAIT_DST, WR_SRC, WR_DST, WR_CNT, FULL} state_t;
  localparam int unsigned ENTRY_WORDS = 3;
`else
  typedef enum logic [2:0] {IDLE, WAIT_DST, WR_SRC, WR_DST, FULL} state_t;
  localparam int unsigned ENTRY_WORDS = 2;
`endif

  // State entered once the destination fetch has been observed.
  localparam state_t E_STATE_FETCH = WR_SRC;

  function automatic logic [15:0] word_addr(input logic [15:0] base, input logic [15:0] idx);
    return base + (idx << 1);
  endfunction

endpackage

// File: rtl/cflog_write_ctrl_if.sv
// Req/ack write port from the CF-Log controller into the log memory.
// Build macro CFLOG_LOOP_COMPRESS_EN does not affect this interface.
interface cflog_write_ctrl_if;
  logic        log_wr_en;
  logic [15:0] log_wr_addr;
  logic [15:0] log_wr_data;
  logic        log_wr_ack;

  modport master (output log_wr_en, log_wr_addr, log_wr_data, input log_wr_ack);
  modport slave  (input log_wr_en, log_wr_addr, log_wr_data, output log_wr_ack);
endinterface

// File: rtl/cflog_wr_port.sv
// Holds one req/ack write: address/data stay put until acked; a load in the ack cycle chains writes.
// Build macro CFLOG_LOOP_COMPRESS_EN does not affect this block.
module cflog_wr_port (
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic [15:0] load_addr,
  input  logic [15:0] load_data,
  input  logic        ack,
  output logic        en,
  output logic [15:0] addr,
  output logic [15:0] data
);

  always_ff @(posedge clk) begin
    if (reset) begin
      en   <= 1'b0;
      addr <= '0;
      data <= '0;
    end else if (load) begin
      en   <= 1'b1;
      addr <= load_addr;
      data <= load_data;
    end else if (en && ack) begin
      en <= 1'b0;
    end
  end

endmodule

// File: rtl/cflog_write_ctrl.sv
// CF-Log write sequencer: captures src/dst PC per branch, writes the entry, halts and flushes when full.
// Build macro CFLOG_LOOP_COMPRESS_EN: 3-word entries (src, dst, count) with repeated-pair count update.
module cflog_write_ctrl
  import cflog_pkg::*;
#(
  parameter logic [15:0] LOG_BASE = 16'hE000,
  parameter logic [15:0] LOG_SIZE = 16'h0040
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [15:0]               pc,
  input  logic                      branch_detect,
  input  logic                      inst_fetch,
  cflog_write_ctrl_if.master        log_port,
  output logic [15:0]               log_ptr,
  output logic                      cpu_halt,
  output logic                      flush_req,
  input  logic                      flush_done,
  output logic                      overflow_err
);

  state_t      state;
  logic [15:0] src, dst;
  logic        load;
  logic [15:0] load_addr, load_data;
  logic        wr_done;
  logic [15:0] ptr_next;

  assign wr_done  = log_port.log_wr_en && log_port.log_wr_ack;
  assign ptr_next = log_ptr + 16'(ENTRY_WORDS);

`ifdef CFLOG_LOOP_COMPRESS_EN
  logic [15:0] last_src, last_dst, last_cnt, cnt_addr;
  logic        last_vld, cnt_only, hit;

  assign hit = last_vld && (src == last_src) && (pc == last_dst) && (last_cnt != 16'hFFFF);
`endif

  always_comb begin
    load      = 1'b0;
    load_addr = word_addr(LOG_BASE, log_ptr);
    load_data = src;
    case (state)
      WAIT_DST: if (inst_fetch) begin
        load = 1'b1;
`ifdef CFLOG_LOOP_COMPRESS_EN
        if (hit) begin
          load_addr = cnt_addr;
          load_data = last_cnt + 16'd1;
        end
`endif
      end
      WR_SRC: if (wr_done) begin
        load      = 1'b1;
        load_addr = word_addr(LOG_BASE, log_ptr + 16'd1);
        load_data = dst;
      end
`ifdef CFLOG_LOOP_COMPRESS_EN
      WR_DST: if (wr_done) begin
        load      = 1'b1;
        load_addr = word_addr(LOG_BASE, log_ptr + 16'd2);
        load_data = 16'd1;
      end
`endif
      default: ;
    endcase
  end

  cflog_wr_port u_wr_port (
    .clk       (clk),
    .reset     (reset),
    .load      (load),
    .load_addr (load_addr),
    .load_data (load_data),
    .ack       (log_port.log_wr_ack),
    .en        (log_port.log_wr_en),
    .addr      (log_port.log_wr_addr),
    .data      (log_port.log_wr_data)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      src          <= '0;
      dst          <= '0;
      log_ptr      <= '0;
      cpu_halt     <= 1'b0;
      flush_req    <= 1'b0;
      overflow_err <= 1'b0;
`ifdef CFLOG_LOOP_COMPRESS_EN
      last_src <= '0;
      last_dst <= '0;
      last_cnt <= '0;
      cnt_addr <= '0;
      last_vld <= 1'b0;
      cnt_only <= 1'b0;
`endif
    end else begin
      // A branch is lost if it collides with the dst fetch or arrives while writing/full.
      if (branch_detect && ((state == WAIT_DST && inst_fetch) ||
                            (state != IDLE && state != WAIT_DST)))
        overflow_err <= 1'b1;
`ifdef CFLOG_LOOP_COMPRESS_EN
      if (flush_done) last_vld <= 1'b0;
`endif
      case (state)
        IDLE: if (branch_detect) begin
          src   <= pc;
          state <= WAIT_DST;
        end
        WAIT_DST: if (inst_fetch) begin
          dst      <= pc;
          cpu_halt <= 1'b1;
`ifdef CFLOG_LOOP_COMPRESS_EN
          cnt_only <= hit;
          state    <= hit ? WR_CNT : E_STATE_FETCH;
`else
          state    <= E_STATE_FETCH;
`endif
        end
        WR_SRC: if (wr_done) state <= WR_DST;
`ifdef CFLOG_LOOP_COMPRESS_EN
        WR_DST: if (wr_done) state <= WR_CNT;
        WR_CNT: if (wr_done) begin
          if (cnt_only) begin
            last_cnt <= last_cnt + 16'd1;
            cpu_halt <= 1'b0;
            state    <= IDLE;
          end else begin
            last_src <= src;
            last_dst <= dst;
            last_cnt <= 16'd1;
            last_vld <= 1'b1;
            cnt_addr <= log_port.log_wr_addr;
            log_ptr  <= ptr_next;
            if (ptr_next == LOG_SIZE) begin
              flush_req <= 1'b1;
              state     <= FULL;
            end else begin
              cpu_halt <= 1'b0;
              state    <= IDLE;
            end
          end
        end
`else
        WR_DST: if (wr_done) begin
          log_ptr <= ptr_next;
          if (ptr_next == LOG_SIZE) begin
            flush_req <= 1'b1;
            state     <= FULL;
          end else begin
            cpu_halt <= 1'b0;
            state    <= IDLE;
          end
        end
`endif
        FULL: if (flush_done) begin
          log_ptr   <= '0;
          flush_req <= 1'b0;
          cpu_halt  <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
